// File: rtl/instr_fetch_align.sv
// Instruction fetch and alignment: a 2-word prefetch FIFO feeding 16/32-bit RISC-V
// instructions to the decoder, with one outstanding memory request at a time.
//
// state | meaning
// IDLE  | nothing outstanding; may issue a request when the FIFO has room
// WAIT  | one valid request outstanding; its data is pushed on rvalid
// FLUSH | one stale request outstanding; its data is dropped on rvalid
module instr_fetch_align #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  state_t      state;
  logic [31:0] word0;
  logic [31:0] word1;
  logic [31:0] faddr;
  logic [31:0] pc;
  logic [1:0]  cnt;
  logic        off;

  logic [15:0] half;
  logic        is_comp;
  logic        hs;
  logic        pop;
  logic        push;

  assign half    = off ? word0[31:16] : word0[15:0];
  assign is_comp = (half[1:0] != 2'b11);

  // An upper-half 32-bit instruction needs its second half from word1.
  assign instr_valid      = (cnt != 2'd0) && !(off && !is_comp && (cnt < 2'd2));
  assign instr_data       = is_comp ? {16'h0000, half}
                          : (off ? {word1[15:0], word0[31:16]} : word0);
  assign instr_compressed = instr_valid && is_comp;
  assign instr_pc         = pc;

  assign imem_req  = !rst && (state == IDLE) && (cnt < 2'd2) && !redirect;
  assign imem_addr = faddr;

  assign hs   = instr_valid && instr_ready && !redirect;
  assign pop  = hs && (off || !is_comp);
  assign push = (state == WAIT) && imem_rvalid && !redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      word0 <= 32'h0;
      word1 <= 32'h0;
      cnt   <= 2'd0;
      off   <= 1'b0;
      pc    <= BOOT_ADDR;
      faddr <= {BOOT_ADDR[31:2], 2'b00};
    end else if (redirect) begin
      cnt   <= 2'd0;
      pc    <= redirect_pc & ~32'd1;
      off   <= redirect_pc[1];
      faddr <= {redirect_pc[31:2], 2'b00};
      case (state)
        IDLE:    state <= IDLE;
        WAIT:    state <= imem_rvalid ? IDLE : FLUSH;
        FLUSH:   state <= imem_rvalid ? IDLE : FLUSH;
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (imem_req && imem_gnt) begin
            state <= WAIT;
            faddr <= faddr + 32'd4;
          end
        end
        WAIT:    if (imem_rvalid) state <= IDLE;
        FLUSH:   if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (hs) begin
        pc <= pc + (is_comp ? 32'd2 : 32'd4);
        if (is_comp) off <= !off;
      end

      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) word0 <= imem_rdata;
          else             word1 <= imem_rdata;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          word0 <= word1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          // Pop then push: incoming word lands behind whatever remains.
          if (cnt == 2'd1) begin
            word0 <= imem_rdata;
          end else begin
            word0 <= word1;
            word1 <= imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_align.sv
// Directed bench for instr_fetch_align: memory handshakes are driven by hand,
// every expected value is written out from the intended behaviour.
module tb_instr_fetch_align;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_compressed;

  int tests = 0;
  int fails = 0;

  instr_fetch_align #(.BOOT_ADDR(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc),
    .instr_compressed (instr_compressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_req",   {31'h0, imem_req}, 32'd0);
    chk("rst_data",  instr_data, 32'h0);
    chk("rst_pc",    instr_pc, 32'h0);
    chk("rst_comp",  {31'h0, instr_compressed}, 32'd0);

    // first fetch from address 0
    rst = 1'b0;
    #1;
    chk("boot_req",  {31'h0, imem_req}, 32'd1);
    chk("boot_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("wait_req",  {31'h0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("w0_valid", {31'h0, instr_valid}, 32'd1);
    chk("w0_data",  instr_data, 32'h00A0_0093);
    chk("w0_pc",    instr_pc, 32'h0);
    chk("w0_comp",  {31'h0, instr_compressed}, 32'd0);
    chk("w0_req",   {31'h0, imem_req}, 32'd1);
    chk("w0_naddr", imem_addr, 32'h4);

    // accept 32-bit instr while address 4 is granted
    instr_ready = 1'b1; imem_gnt = 1'b1;
    tick();
    instr_ready = 1'b0; imem_gnt = 1'b0;
    chk("pop_valid", {31'h0, instr_valid}, 32'd0);
    chk("pop_pc",    instr_pc, 32'h4);
    imem_rvalid = 1'b1; imem_rdata = 32'h0513_4501;
    tick();
    imem_rvalid = 1'b0;
    chk("c_valid", {31'h0, instr_valid}, 32'd1);
    chk("c_data",  instr_data, 32'h0000_4501);
    chk("c_comp",  {31'h0, instr_compressed}, 32'd1);
    chk("c_pc",    instr_pc, 32'h4);

    // compressed consumed; upper half starts a 32-bit instr that straddles words
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("strad_wait_valid", {31'h0, instr_valid}, 32'd0);
    chk("strad_pc",         instr_pc, 32'h6);
    chk("strad_req",        {31'h0, imem_req}, 32'd1);
    chk("strad_addr",       imem_addr, 32'h8);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h4581_0005;
    tick();
    imem_rvalid = 1'b0;
    chk("strad_valid", {31'h0, instr_valid}, 32'd1);
    chk("strad_data",  instr_data, 32'h0005_0513);
    chk("strad_comp",  {31'h0, instr_compressed}, 32'd0);
    chk("full_req",    {31'h0, imem_req}, 32'd0);

    // backpressure with both FIFO entries full
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_req",   {31'h0, imem_req}, 32'd0);
      chk("bp_valid", {31'h0, instr_valid}, 32'd1);
      chk("bp_data",  instr_data, 32'h0005_0513);
      chk("bp_pc",    instr_pc, 32'h6);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("resume_data", instr_data, 32'h0000_4581);
    chk("resume_comp", {31'h0, instr_compressed}, 32'd1);
    chk("resume_pc",   instr_pc, 32'hA);
    chk("resume_req",  {31'h0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'hC);

    // redirect while a request is outstanding
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    #1;
    chk("redir_req_low", {31'h0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    chk("flush_valid", {31'h0, instr_valid}, 32'd0);
    chk("flush_pc",    instr_pc, 32'h102);
    chk("flush_req",   {31'h0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("stale_valid", {31'h0, instr_valid}, 32'd0);
    chk("refetch_req", {31'h0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, 32'h100);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h4505_0000;
    tick();
    imem_rvalid = 1'b0;
    chk("upper_valid", {31'h0, instr_valid}, 32'd1);
    chk("upper_data",  instr_data, 32'h0000_4505);
    chk("upper_pc",    instr_pc, 32'h102);

    // redirect beats a same-cycle handshake; bit 0 of the target is dropped
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0201;
    tick();
    instr_ready = 1'b0; redirect = 1'b0;
    chk("redir_hs_pc",    instr_pc, 32'h200);
    chk("redir_hs_valid", {31'h0, instr_valid}, 32'd0);
    chk("redir_hs_addr",  imem_addr, 32'h200);

    // fetch address and pc wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("wrap_faddr", imem_addr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("wrap_valid", {31'h0, instr_valid}, 32'd1);
    chk("wrap_pc0",   instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("wrap_pc1", instr_pc, 32'h0);

    // reset while a request is outstanding; the late response is ignored
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'h0, imem_req}, 32'd0);
    chk("midrst_pc",  instr_pc, 32'h0);
    tick();
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_1234;
    tick();
    imem_rvalid = 1'b0;
    chk("late_valid", {31'h0, instr_valid}, 32'd0);
    chk("late_req",   {31'h0, imem_req}, 32'd1);
    chk("late_addr",  imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
